// File: rtl/rf_pkg.sv
// Shared defaults and per-port state encoding for the two-read, one-write register file.
package rf_pkg;

    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 8;
    localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } port_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: IDLE/VALID state, same-edge write bypass and data output register.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    port_state_e       state_r;
    port_state_e       state_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] capture_s;
    logic              bypass_s;
    logic              valid_s;

    // port state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state: a request always lands in VALID, no request returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) state_nxt_s = VALID;
                else     state_nxt_s = IDLE;
            end
            VALID: begin
                if (req) state_nxt_s = VALID;
                else     state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // valid is a pure decode of the state flop
    always_comb begin
        valid_s = 1'b0;
        case (state_r)
            VALID:   valid_s = 1'b1;
            IDLE:    valid_s = 1'b0;
            default: valid_s = 1'b0;
        endcase
    end

    assign bypass_s = we && (waddr == addr) && (addr != {ADDR_W{1'b0}});

    // capture source; address 0 is forced to zero so a discarded write cannot leak through
    always_comb begin
        capture_s = {DATA_W{1'b0}};
        if (addr == {ADDR_W{1'b0}}) begin
            capture_s = {DATA_W{1'b0}};
        end else if (bypass_s) begin
            capture_s = wdata;
        end else begin
            capture_s = mem_data;
        end
    end

    // output data register; holds its last value whenever no request is made
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (req) begin
            data_r <= capture_s;
        end else begin
            data_r <= data_r;
        end
    end

    assign data  = data_r;
    assign valid = valid_s;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two independent registered read ports and one write port; register 0 reads as zero.
module regfile_2r1w
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ra_req,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic              rb_req,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic              ra_valid,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid
);

    logic [DATA_W-1:0] mem_r [NUM_REGS];
    logic [DATA_W-1:0] mem_a_s;
    logic [DATA_W-1:0] mem_b_s;
    logic              wr_en_s;

    assign wr_en_s = we && (waddr != {ADDR_W{1'b0}});

    // storage; entry 0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r <= '{default: {DATA_W{1'b0}}};
        end else if (wr_en_s) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign mem_a_s = mem_r[ra_addr];
    assign mem_b_s = mem_r[rb_addr];

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .req      (ra_req),
        .addr     (ra_addr),
        .mem_data (mem_a_s),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .data     (ra_data),
        .valid    (ra_valid)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .req      (rb_req),
        .addr     (rb_addr),
        .mem_data (mem_b_s),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .data     (rb_data),
        .valid    (rb_valid)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: stimulus pushes expected read results, a negedge monitor pops and compares.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        ra_req;
    logic [2:0]  ra_addr;
    logic        rb_req;
    logic [2:0]  rb_addr;
    logic [15:0] ra_data;
    logic        ra_valid;
    logic [15:0] rb_data;
    logic        rb_valid;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc;
    int   nvec;
    int   nerr;

    regfile_2r1w dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .ra_req   (ra_req),
        .ra_addr  (ra_addr),
        .rb_req   (rb_req),
        .rb_addr  (rb_addr),
        .ra_data  (ra_data),
        .ra_valid (ra_valid),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input logic [2:0] a, input logic [15:0] exp);
        exp_t e;
        ra_req  = 1'b1;
        ra_addr = a;
        e.data  = exp;
        e.due   = cyc + 1;
        qa.push_back(e);
    endtask

    task automatic read_b(input logic [2:0] a, input logic [15:0] exp);
        exp_t e;
        rb_req  = 1'b1;
        rb_addr = a;
        e.data  = exp;
        e.due   = cyc + 1;
        qb.push_back(e);
    endtask

    task automatic idle_inputs();
        we     = 1'b0;
        ra_req = 1'b0;
        rb_req = 1'b0;
    endtask

    // monitor: pop on valid, and flag any expected read whose cycle passed without valid
    always @(negedge clk) begin
        exp_t e;
        if (ra_valid) begin
            if (qa.size() == 0) begin
                check_int("A unexpected valid", 1, 0);
            end else begin
                e = qa.pop_front();
                check("A data", ra_data, e.data);
                check_int("A latency", cyc, e.due);
            end
        end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            check_int("A missing valid", 0, 1);
        end
        if (rb_valid) begin
            if (qb.size() == 0) begin
                check_int("B unexpected valid", 1, 0);
            end else begin
                e = qb.pop_front();
                check("B data", rb_data, e.data);
                check_int("B latency", cyc, e.due);
            end
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            check_int("B missing valid", 0, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; nvec = 0; nerr = 0;
        rst = 1'b1;
        idle_inputs();
        waddr = 3'd0; wdata = 16'h0000; ra_addr = 3'd0; rb_addr = 3'd0;
        #12;
        check("reset ra_valid", {15'd0, ra_valid}, 16'h0000);
        check("reset rb_valid", {15'd0, rb_valid}, 16'h0000);
        check("reset ra_data", ra_data, 16'h0000);
        check("reset rb_data", rb_data, 16'h0000);

        // write during reset must be discarded
        we = 1'b1; waddr = 3'd3; wdata = 16'hFFFF;
        step();
        rst = 1'b0; idle_inputs();
        read_a(3'd3, 16'h0000);
        step(); idle_inputs();

        // basic write then dual read of the same register
        we = 1'b1; waddr = 3'd5; wdata = 16'h1234;
        step(); idle_inputs();
        read_a(3'd5, 16'h1234);
        read_b(3'd5, 16'h1234);
        step(); idle_inputs();

        // same-edge write bypass on port A
        we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF;
        read_a(3'd2, 16'hBEEF);
        step(); idle_inputs();

        // register 0: write discarded, same-edge write to 0 does not bypass
        we = 1'b1; waddr = 3'd0; wdata = 16'hAAAA;
        step(); idle_inputs();
        read_b(3'd0, 16'h0000);
        step(); idle_inputs();
        we = 1'b1; waddr = 3'd0; wdata = 16'h5555;
        read_b(3'd0, 16'h0000);
        step(); idle_inputs();

        // back-to-back reads on A keep VALID and capture new data
        read_a(3'd5, 16'h1234);
        step();
        read_a(3'd2, 16'hBEEF);
        step(); idle_inputs();

        // both ports on the same address with bypass
        we = 1'b1; waddr = 3'd7; wdata = 16'hCAFE;
        read_a(3'd7, 16'hCAFE);
        read_b(3'd7, 16'hCAFE);
        step(); idle_inputs();

        // hold: data stays after req drops even though storage changes
        we = 1'b1; waddr = 3'd4; wdata = 16'h0042;
        step(); idle_inputs();
        read_a(3'd4, 16'h0042);
        step(); idle_inputs();
        we = 1'b1; waddr = 3'd4; wdata = 16'h0099;
        step(); idle_inputs();
        check("hold ra_valid", {15'd0, ra_valid}, 16'h0000);
        check("hold ra_data", ra_data, 16'h0042);
        read_b(3'd4, 16'h0099);
        step(); idle_inputs();

        // asynchronous reset between edges while A is valid
        read_a(3'd5, 16'h1234);
        step(); idle_inputs();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async rst ra_valid", {15'd0, ra_valid}, 16'h0000);
        check("async rst ra_data", ra_data, 16'h0000);
        step();
        rst = 1'b0;
        read_a(3'd5, 16'h0000);
        step(); idle_inputs();

        repeat (3) step();
        check_int("A queue drained", qa.size(), 0);
        check_int("B queue drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
